demux4_buf: RTL and testbench
=============================

Name: demux4_buf

Overview:
- 1-to-4 registered demultiplexer, the distributing counterpart of the 4:1 32-bit selector used in the datapath and display paths.
- Routes one 32-bit input word to one of four output channels chosen by a 2-bit select. Each channel holds a one-entry output buffer with valid/ready flow control.
- Sits between a producer (CPU result or write-back bus) and four consumers (display, LED, debug, and I/O registers).
- Keeps a per-channel count of delivered words for debug readout.

Parameters:
- WIDTH, 32, data word width.
- CNT_W, 8, width of each per-channel delivery counter.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- sel  in  2  destination channel for the current input word (00 = ch0 … 11 = ch3).
- in_data  in  WIDTH  input word.
- in_valid  in  1  producer offers in_data/sel this cycle.
- in_ready  out  1  block accepts the offered word this cycle (combinational).
- out_data0..out_data3  out  WIDTH each  buffered word of channel k.
- out_valid  out  4  bit k set = channel k buffer holds an undelivered word.
- out_ready  in  4  bit k set = consumer k takes its word this cycle.
- cnt_all  out  4*CNT_W  packed delivery counters; ch0 in the LSBs.

Behaviour:
- Definitions:
  - drain[k] = out_valid[k] & out_ready[k].
  - in_ready = ~out_valid[sel] | out_ready[sel]. It depends only on the selected channel. Pass-through on the same cycle a slot frees is allowed.
  - accept = in_valid & in_ready.
- Reset (rst=1 at a clock edge):
  - out_valid = 0000, all out_dataN = 0, all counters = 0.
  - Words held in the buffers are discarded, not delivered.
  - in_ready during reset follows the combinational rule on the post-reset state, but nothing is captured while rst=1.
- Per channel k, each cycle (no reset):
  - accept & sel==k: out_data_k <= in_data, out_valid[k] <= 1. This applies even if drain[k] occurs the same cycle (back-to-back streaming, no bubble).
  - Otherwise, if drain[k]: out_valid[k] <= 0. out_data_k keeps its last value.
  - Otherwise: hold.
- Latency: an accepted word appears on out_data_sel with out_valid set the cycle after acceptance.
- Throughput: one word per cycle to one channel if its consumer drains every cycle. Channels are independent: a stalled channel does not block words destined for other channels.
- Stability: while out_valid[k]=1 and out_ready[k]=0, out_data_k and out_valid[k] stay constant.
- Non-selected channels: never written. A full non-selected channel does not affect in_ready.
- in_valid=0: no capture. sel and in_data are don't-care.
- Counters:
  - cnt[k] increments by 1 on each drain[k] and wraps from 2^CNT_W-1 to 0.
  - Counting is independent of simultaneous accepts.
  - cnt_all[k*CNT_W +: CNT_W] = cnt[k], registered.
- out_ready[k] while out_valid[k]=0: ignored. No counter change, no state change.
- No combinational path from in_data to outputs. The only combinational output is in_ready, which depends on sel and out_valid/out_ready.

Test Plan:
- Reset:
  - Drive rst=1 for 2 cycles with in_valid=1, sel=01, in_data=0xDEADBEEF.
  - Expect out_valid=0000, all out_data=0, cnt_all=0 throughout and on the first cycle after release.
- Basic routing:
  - Cycles 0-3: send 0x11111111, 0x22222222, 0x33333333, 0x44444444 with sel=00,01,10,11, out_ready=0000.
  - Expect each channel valid one cycle after its send with the matching data.
  - After cycle 3, out_valid=1111.
- Backpressure:
  - With ch2 full and out_ready[2]=0, offer sel=10, 0xAAAA0000: expect in_ready=0 and out_data2 unchanged.
  - Switch the offer to sel=00 with ch0 empty: expect in_ready=1 and capture.
- Pass-through:
  - ch1 holds 0x5; set out_ready[1]=1 and offer sel=01, 0x6 in the same cycle.
  - Expect in_ready=1. Next cycle out_valid[1]=1, out_data1=0x6, cnt1=1.
- Counter wrap:
  - Stream 257 words to ch3 with out_ready[3]=1 every cycle.
  - Expect cnt3 to go 255 → 0 → 1, with the other counters remaining 0.
- Reset mid-operation:
  - With out_valid=1011 and cnt0=7, pulse rst for 1 cycle.
  - Expect out_valid=0000 and cnt_all=0 next cycle, and no drain counted for the discarded words.

Source files
------------

// File: rtl/demux4_buf_if.sv
// Producer/consumer bus for the 1-to-4 buffered demultiplexer.
// The slave modport is the demux side; the master side drives words in and takes them out.
interface demux4_buf_if #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
);
  logic [1:0]         sel;
  logic [WIDTH-1:0]   in_data;
  logic               in_valid;
  logic               in_ready;
  logic [WIDTH-1:0]   out_data0;
  logic [WIDTH-1:0]   out_data1;
  logic [WIDTH-1:0]   out_data2;
  logic [WIDTH-1:0]   out_data3;
  logic [3:0]         out_valid;
  logic [3:0]         out_ready;
  logic [4*CNT_W-1:0] cnt_all;

  modport slave (
    input  sel, in_data, in_valid, out_ready,
    output in_ready, out_data0, out_data1, out_data2, out_data3, out_valid, cnt_all
  );

  modport master (
    output sel, in_data, in_valid, out_ready,
    input  in_ready, out_data0, out_data1, out_data2, out_data3, out_valid, cnt_all
  );
endinterface

// File: rtl/demux4_buf.sv
// Registered 1-to-4 demultiplexer with a one-entry valid/ready buffer per channel
// and a wrapping delivery counter per channel for debug readout.
module demux4_buf #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 8
) (
  input  logic          clk,
  input  logic          rst,
  demux4_buf_if.slave   bus
);

  logic [WIDTH-1:0] data_q [4];
  logic [WIDTH-1:0] data_d [4];
  logic [3:0]       valid_q;
  logic [3:0]       valid_d;
  logic [CNT_W-1:0] cnt_q  [4];
  logic [CNT_W-1:0] cnt_d  [4];
  logic             accept;
  logic [3:0]       drain;

  // Only the selected slot matters: a full but unselected channel never stalls the producer.
  assign bus.in_ready = ~valid_q[bus.sel] | bus.out_ready[bus.sel];
  assign accept       = bus.in_valid & bus.in_ready;
  assign drain        = valid_q & bus.out_ready;

  // A new word takes priority over a same-cycle drain so a streaming channel never bubbles.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q;
    cnt_d   = cnt_q;
    for (int k = 0; k < 4; k++) begin
      if (accept && (bus.sel == 2'(k))) begin
        data_d[k]  = bus.in_data;
        valid_d[k] = 1'b1;
      end else if (drain[k]) begin
        valid_d[k] = 1'b0;
      end
      if (drain[k]) begin
        cnt_d[k] = cnt_q[k] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
      for (int k = 0; k < 4; k++) begin
        data_q[k] <= '0;
        cnt_q[k]  <= '0;
      end
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign bus.out_data0 = data_q[0];
  assign bus.out_data1 = data_q[1];
  assign bus.out_data2 = data_q[2];
  assign bus.out_data3 = data_q[3];
  assign bus.out_valid = valid_q;

  for (genvar g = 0; g < 4; g++) begin : gCnt
    assign bus.cnt_all[g*CNT_W +: CNT_W] = cnt_q[g];
  end

endmodule

// File: tb/tb_demux4_buf.sv
// Directed self-checking bench for demux4_buf: reset, routing, backpressure,
// pass-through, counter wrap and mid-operation reset.
module tb_demux4_buf;
  localparam int WIDTH = 32;
  localparam int CNT_W = 8;

  logic clk;
  logic rst;
  int   compared;
  int   mismatched;

  demux4_buf_if #(.WIDTH(WIDTH), .CNT_W(CNT_W)) bus ();

  demux4_buf #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL timeout: simulation ran past its time limit");
    $fatal(1, "[TB] timeout");
  end

  function automatic logic [WIDTH-1:0] getData(input int k);
    case (k)
      0:       getData = bus.out_data0;
      1:       getData = bus.out_data1;
      2:       getData = bus.out_data2;
      default: getData = bus.out_data3;
    endcase
  endfunction

  function automatic logic [CNT_W-1:0] getCnt(input int k);
    getCnt = bus.cnt_all[k*CNT_W +: CNT_W];
  endfunction

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulseReset();
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b0000;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.in_valid  = 1'b1;
    bus.sel       = 2'b01;
    bus.in_data   = 32'hDEADBEEF;
    bus.out_ready = 4'b0000;
    for (int c = 0; c < 3; c++) begin
      if (c == 2) begin
        rst = 1'b0;
        bus.in_valid = 1'b0;
      end
      step();
      compared++;
      if (bus.out_valid !== 4'b0000) begin
        mismatched++;
        $display("[TB] FAIL reset_valid c=%0d: got %b expected 0000", c, bus.out_valid);
      end
      compared++;
      if (bus.cnt_all !== '0) begin
        mismatched++;
        $display("[TB] FAIL reset_cnt c=%0d: got %h expected 0", c, bus.cnt_all);
      end
      for (int k = 0; k < 4; k++) begin
        compared++;
        if (getData(k) !== '0) begin
          mismatched++;
          $display("[TB] FAIL reset_data%0d c=%0d: got %h expected 0", k, c, getData(k));
        end
      end
    end
    compared++;
    if (bus.in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", bus.in_ready);
    end
  endtask

  task automatic test_routing();
    logic [WIDTH-1:0] words [4];
    words[0] = 32'h11111111;
    words[1] = 32'h22222222;
    words[2] = 32'h33333333;
    words[3] = 32'h44444444;
    bus.out_ready = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      bus.sel      = 2'(i);
      bus.in_data  = words[i];
      bus.in_valid = 1'b1;
      #1;
      compared++;
      if (bus.in_ready !== 1'b1) begin
        mismatched++;
        $display("[TB] FAIL route_in_ready%0d: got %b expected 1", i, bus.in_ready);
      end
      step();
      compared++;
      if (bus.out_valid[i] !== 1'b1 || getData(i) !== words[i]) begin
        mismatched++;
        $display("[TB] FAIL route_ch%0d: got valid=%b data=%h expected valid=1 data=%h",
                 i, bus.out_valid[i], getData(i), words[i]);
      end
    end
    bus.in_valid = 1'b0;
    compared++;
    if (bus.out_valid !== 4'b1111) begin
      mismatched++;
      $display("[TB] FAIL route_all_valid: got %b expected 1111", bus.out_valid);
    end
  endtask

  task automatic test_backpressure();
    bus.out_ready = 4'b0000;
    bus.sel       = 2'b10;
    bus.in_data   = 32'hAAAA0000;
    bus.in_valid  = 1'b1;
    #1;
    compared++;
    if (bus.in_ready !== 1'b0) begin
      mismatched++;
      $display("[TB] FAIL bp_in_ready_full: got %b expected 0", bus.in_ready);
    end
    step();
    compared++;
    if (bus.out_data2 !== 32'h33333333 || bus.out_valid[2] !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL bp_ch2_hold: got valid=%b data=%h expected valid=1 data=33333333",
               bus.out_valid[2], bus.out_data2);
    end
    // Empty ch0 so the redirected offer has somewhere to land.
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b0001;
    step();
    compared++;
    if (bus.out_valid !== 4'b1110 || getCnt(0) !== 8'd1) begin
      mismatched++;
      $display("[TB] FAIL bp_drain_ch0: got valid=%b cnt0=%0d expected valid=1110 cnt0=1",
               bus.out_valid, getCnt(0));
    end
    bus.out_ready = 4'b0000;
    bus.sel       = 2'b00;
    bus.in_valid  = 1'b1;
    #1;
    compared++;
    if (bus.in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL bp_in_ready_other: got %b expected 1", bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    compared++;
    if (bus.out_data0 !== 32'hAAAA0000 || bus.out_valid !== 4'b1111 ||
        bus.out_data2 !== 32'h33333333) begin
      mismatched++;
      $display("[TB] FAIL bp_capture_ch0: got valid=%b d0=%h d2=%h expected 1111 AAAA0000 33333333",
               bus.out_valid, bus.out_data0, bus.out_data2);
    end
  endtask

  task automatic test_pass_through();
    pulseReset();
    bus.sel      = 2'b01;
    bus.in_data  = 32'h5;
    bus.in_valid = 1'b1;
    step();
    bus.out_ready = 4'b0010;
    bus.in_data   = 32'h6;
    #1;
    compared++;
    if (bus.in_ready !== 1'b1) begin
      mismatched++;
      $display("[TB] FAIL pt_in_ready: got %b expected 1", bus.in_ready);
    end
    step();
    bus.in_valid = 1'b0;
    compared++;
    if (bus.out_valid !== 4'b0010 || bus.out_data1 !== 32'h6 || getCnt(1) !== 8'd1) begin
      mismatched++;
      $display("[TB] FAIL pt_result: got valid=%b d1=%h cnt1=%0d expected 0010 6 1",
               bus.out_valid, bus.out_data1, getCnt(1));
    end
    step();
    bus.out_ready = 4'b0000;
    compared++;
    if (bus.out_valid !== 4'b0000 || bus.out_data1 !== 32'h6 || getCnt(1) !== 8'd2) begin
      mismatched++;
      $display("[TB] FAIL pt_drain: got valid=%b d1=%h cnt1=%0d expected 0000 6 2",
               bus.out_valid, bus.out_data1, getCnt(1));
    end
    // Ready on an empty channel must not count.
    bus.out_ready = 4'b1111;
    step();
    bus.out_ready = 4'b0000;
    compared++;
    if (bus.cnt_all !== 32'h00000200) begin
      mismatched++;
      $display("[TB] FAIL pt_idle_ready: got cnt_all=%h expected 00000200", bus.cnt_all);
    end
  endtask

  task automatic test_counter_wrap();
    logic [CNT_W-1:0] expCnt;
    pulseReset();
    bus.out_ready = 4'b1000;
    bus.sel       = 2'b11;
    bus.in_valid  = 1'b1;
    // First edge only captures; every later edge drains the previous word.
    for (int i = 1; i <= 257; i++) begin
      bus.in_data = 32'(i);
      step();
      expCnt = CNT_W'(i - 1);
      compared++;
      if (getCnt(3) !== expCnt || bus.out_valid[3] !== 1'b1 || bus.out_data3 !== 32'(i)) begin
        mismatched++;
        $display("[TB] FAIL wrap_step%0d: got cnt3=%0d valid=%b d3=%h expected cnt3=%0d valid=1 d3=%h",
                 i, getCnt(3), bus.out_valid[3], bus.out_data3, expCnt, 32'(i));
      end
    end
    bus.in_valid = 1'b0;
    step();
    bus.out_ready = 4'b0000;
    compared++;
    if (bus.cnt_all !== 32'h01000000 || bus.out_valid !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL wrap_final: got cnt_all=%h valid=%b expected 01000000 0000",
               bus.cnt_all, bus.out_valid);
    end
  endtask

  task automatic test_reset_mid();
    pulseReset();
    bus.out_ready = 4'b0001;
    bus.sel       = 2'b00;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 7; i++) begin
      bus.in_data = 32'h100 + 32'(i);
      step();
    end
    bus.in_valid = 1'b0;
    step();
    bus.out_ready = 4'b0000;
    bus.in_valid  = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i != 2) begin
        bus.sel     = 2'(i);
        bus.in_data = 32'hC0DE0000 + 32'(i);
        step();
      end
    end
    bus.in_valid = 1'b0;
    compared++;
    if (bus.out_valid !== 4'b1011 || bus.cnt_all !== 32'h00000007) begin
      mismatched++;
      $display("[TB] FAIL mid_setup: got valid=%b cnt_all=%h expected 1011 00000007",
               bus.out_valid, bus.cnt_all);
    end
    rst = 1'b1;
    bus.out_ready = 4'b1111;
    step();
    rst = 1'b0;
    bus.out_ready = 4'b0000;
    compared++;
    if (bus.out_valid !== 4'b0000 || bus.cnt_all !== '0 || bus.out_data0 !== '0 ||
        bus.out_data3 !== '0) begin
      mismatched++;
      $display("[TB] FAIL mid_reset: got valid=%b cnt_all=%h d0=%h d3=%h expected all 0",
               bus.out_valid, bus.cnt_all, bus.out_data0, bus.out_data3);
    end
    step();
    compared++;
    if (bus.cnt_all !== '0 || bus.out_valid !== 4'b0000) begin
      mismatched++;
      $display("[TB] FAIL mid_after: got valid=%b cnt_all=%h expected 0000 0",
               bus.out_valid, bus.cnt_all);
    end
  endtask

  initial begin
    compared      = 0;
    mismatched    = 0;
    rst           = 1'b1;
    bus.sel       = 2'b00;
    bus.in_data   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 4'b0000;
    test_reset();
    test_routing();
    test_backpressure();
    test_pass_through();
    test_counter_wrap();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
